// File: rtl/dac_output_stage_pkg.sv
// dac_output_stage_pkg
//   Shared definitions for the DAC output stage: default data widths,
//   the offset-binary midscale code for the default DAC width, and a
//   generic signed saturation helper used by the output stage.
//   No ports (package).

package dac_output_stage_pkg;

  // Default widths of the mixer sample and the DAC word.
  localparam int DAC_IN_W  = 24;
  localparam int DAC_OUT_W = 16;

  // Offset-binary code for 0 V at the default DAC width.
  localparam logic [DAC_OUT_W-1:0] DAC_MIDSCALE = 16'h8000;

  // Clamp a signed value to the two's-complement range of a w-bit word.
  // Works on a 64-bit carrier so one function serves any width up to 64.
  function automatic logic signed [63:0] dac_saturate(
    input logic signed [63:0] value,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// dac_tick_gen
//   Free-running divider that sets the DAC update rate. The counter runs
//   0..TICK_DIV-1 and wraps; o_tick is high for the single cycle in which
//   the counter sits at its terminal value.
// Ports:
//   i_clk    in   system clock
//   i_reset  in   asynchronous active-low reset (counter returns to 0)
//   o_tick   out  one-cycle update strobe, once every TICK_DIV clocks

module dac_tick_gen #(
  parameter int TICK_DIV = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (count == TERM) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign o_tick = (count == TERM);

endmodule

// File: rtl/dac_output_stage.sv
// dac_output_stage
//   Paced, buffered output path between the voice mixer and the parallel
//   audio DAC. Samples arrive over a valid/ready handshake into a one-entry
//   holding register. On each divider tick the held sample is shifted by
//   BASE_SHIFT + i_gain_shift into stage 1; stage 2 saturates it to the DAC
//   width, converts to offset binary (or forces midscale when muted) and
//   reports clipping. A tick with nothing held repeats the last sample and
//   pulses o_underrun.
//
// Optional build macro:
//   DAC_DITHER_EN  adds a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed
//                  0xACE1) whose low s bits are added before the shift for
//                  stochastic rounding. Undefined: pure truncation.
//
// Ports:
//   i_clk           in   system clock
//   i_reset         in   asynchronous active-low reset
//   i_sample        in   signed mixed sample (IN_W)
//   i_sample_valid  in   i_sample is valid
//   o_sample_ready  out  stage accepts a sample this cycle
//   i_gain_shift    in   extra right shift 0..7, sampled at the tick
//   i_mute          in   forces the DAC word to midscale, no clip reporting
//   i_clip_clear    in   zeroes o_clip_count
//   o_dac_out       out  offset-binary DAC word (OUT_W)
//   o_dac_load      out  one-cycle pulse when o_dac_out is updated
//   o_clip          out  held high for CLIP_HOLD clocks after the last clip
//   o_clip_count    out  saturating count of clipped samples
//   o_underrun      out  one-cycle pulse after a tick with no sample held

module dac_output_stage
  import dac_output_stage_pkg::*;
#(
  parameter int IN_W       = DAC_IN_W,
  parameter int OUT_W      = DAC_OUT_W,
  parameter int BASE_SHIFT = 3,
  parameter int TICK_DIV   = 1024,
  parameter int CLIP_HOLD  = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [IN_W-1:0]   i_sample,
  input  logic              i_sample_valid,
  output logic              o_sample_ready,
  input  logic [2:0]        i_gain_shift,
  input  logic              i_mute,
  input  logic              i_clip_clear,
  output logic [OUT_W-1:0]  o_dac_out,
  output logic              o_dac_load,
  output logic              o_clip,
  output logic [15:0]       o_clip_count,
  output logic              o_underrun
);

  localparam int SH_W   = $clog2(IN_W);
  localparam int HOLD_W = $clog2(CLIP_HOLD + 1);
  localparam logic [OUT_W-1:0]  MIDSCALE = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(CLIP_HOLD);

  // ---------------------------------------------------------------------
  // Update pacing
  // ---------------------------------------------------------------------
  logic tick;

  dac_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  // ---------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------
  logic                   pending;
  logic signed [IN_W-1:0] held;
  logic                   handshake;

  // The tick frees the holding register in the same cycle, so a new sample
  // can be accepted while the old one moves on.
  assign o_sample_ready = !pending || tick;
  assign handshake      = i_sample_valid && o_sample_ready;

  // ---------------------------------------------------------------------
  // Stage 1 input: optional dither, then gain shift
  // ---------------------------------------------------------------------
  logic [SH_W-1:0]        shift_amt;
  logic signed [IN_W-1:0] pre_shift;
  logic signed [IN_W-1:0] shifted;

  assign shift_amt = SH_W'(BASE_SHIFT) + SH_W'(i_gain_shift);

`ifdef DAC_DITHER_EN
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [IN_W:0]   dither_mask;
  logic [IN_W:0]   dither;
  logic [IN_W:0]   dither_sum;

  // Right-shifting Galois form; 0xB400 places the x^16, x^14, x^13, x^11 taps.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lfsr <= 16'hACE1;
    end else if (tick) begin
      lfsr <= lfsr_next;
    end
  end

  // Only the bits about to be shifted out receive dither, so the sum
  // rounds up with probability equal to the discarded fraction.
  assign dither_mask = ({{IN_W{1'b0}}, 1'b1} << shift_amt) - {{IN_W{1'b0}}, 1'b1};
  assign dither      = {{(IN_W + 1 - 16){1'b0}}, lfsr} & dither_mask;
  assign dither_sum  = {held[IN_W-1], held} + dither;

  // A non-negative addend can only overflow toward +full-scale.
  always_comb begin
    pre_shift = dither_sum[IN_W-1:0];
    if (dither_sum[IN_W] != dither_sum[IN_W-1]) begin
      pre_shift = {1'b0, {(IN_W - 1){1'b1}}};
    end
  end
`else
  assign pre_shift = held;
`endif

  // Arithmetic shift truncates toward minus infinity.
  assign shifted = pre_shift >>> shift_amt;

  // ---------------------------------------------------------------------
  // Holding register, stage 1 and underrun
  // ---------------------------------------------------------------------
  logic signed [IN_W-1:0] stage1;
  logic                   stage1_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pending      <= 1'b0;
      held         <= '0;
      stage1       <= '0;
      stage1_valid <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      stage1_valid <= 1'b0;
      o_underrun   <= 1'b0;
      if (tick) begin
        if (pending) begin
          stage1       <= shifted;
          stage1_valid <= 1'b1;
        end else begin
          // stage1 keeps its value: the last sample repeats on the DAC.
          o_underrun <= 1'b1;
        end
        pending <= handshake;
        if (handshake) begin
          held <= i_sample;
        end
      end else if (handshake) begin
        held    <= i_sample;
        pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: saturation, offset binary, mute, clip detection
  // ---------------------------------------------------------------------
  logic signed [63:0] stage1_wide;
  logic signed [63:0] sat_value;
  logic               sat_hit;
  logic [OUT_W-1:0]   dac_word;
  logic               clip_event;

  assign stage1_wide = {{(64 - IN_W){stage1[IN_W-1]}}, stage1};
  assign sat_value   = dac_saturate(stage1_wide, OUT_W);
  assign sat_hit     = (sat_value != stage1_wide);

  // Flipping the sign bit maps two's complement onto offset binary.
  assign dac_word    = {~sat_value[OUT_W-1], sat_value[OUT_W-2:0]};

  // Muting hides the sample entirely, including any clip it would cause.
  assign clip_event  = stage1_valid && !i_mute && sat_hit;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_dac_out  <= MIDSCALE;
      o_dac_load <= 1'b0;
    end else begin
      o_dac_load <= stage1_valid;
      if (stage1_valid) begin
        o_dac_out <= i_mute ? MIDSCALE : dac_word;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Clip hold timer and clip counter
  // ---------------------------------------------------------------------
  logic [HOLD_W-1:0] clip_hold;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      clip_hold <= '0;
    end else if (clip_event) begin
      clip_hold <= HOLD_RELOAD;
    end else if (clip_hold != '0) begin
      clip_hold <= clip_hold - HOLD_W'(1);
    end
  end

  assign o_clip = (clip_hold != '0);

  // A clear that coincides with a clip keeps that clip in the new count.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_clip_count <= '0;
    end else if (i_clip_clear) begin
      o_clip_count <= clip_event ? 16'd1 : 16'd0;
    end else if (clip_event && (o_clip_count != 16'hFFFF)) begin
      o_clip_count <= o_clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_output_stage.sv
// tb_dac_output_stage
//   Directed bench for dac_output_stage with TICK_DIV = 8 and defaults
//   otherwise. Each test task drives its scenario and checks inline.

module tb_dac_output_stage;

  localparam int TD = 8;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [23:0] i_sample = '0;
  logic        i_sample_valid = 1'b0;
  logic        o_sample_ready;
  logic [2:0]  i_gain_shift = '0;
  logic        i_mute = 1'b0;
  logic        i_clip_clear = 1'b0;
  logic [15:0] o_dac_out;
  logic        o_dac_load;
  logic        o_clip;
  logic [15:0] o_clip_count;
  logic        o_underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;

  // Reference divider: tick when the count sits at TD-1.
  int   tb_cnt;
  logic tb_tick;

  always #5 i_clk = ~i_clk;

  dac_output_stage #(
    .TICK_DIV (TD)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .i_gain_shift   (i_gain_shift),
    .i_mute         (i_mute),
    .i_clip_clear   (i_clip_clear),
    .o_dac_out      (o_dac_out),
    .o_dac_load     (o_dac_load),
    .o_clip         (o_clip),
    .o_clip_count   (o_clip_count),
    .o_underrun     (o_underrun)
  );

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) tb_cnt <= 0;
    else          tb_cnt <= (tb_cnt == TD - 1) ? 0 : tb_cnt + 1;
  end
  assign tb_tick = (tb_cnt == TD - 1);

  always @(negedge i_clk) if (o_dac_load) load_cnt++;

  // Present a sample and hold valid until the handshake edge; returns just
  // after that edge. at_tick reports whether the handshake fell on a tick.
  task automatic push(input logic [23:0] s, output bit at_tick);
    bit rdy;
    bit done;
    done = 0;
    at_tick = 0;
    @(negedge i_clk);
    i_sample = s;
    i_sample_valid = 1'b1;
    for (int n = 0; n < 4 * TD; n++) begin
      rdy = o_sample_ready;
      at_tick = tb_tick;
      @(posedge i_clk);
      if (rdy) begin
        done = 1;
        break;
      end
      @(negedge i_clk);
    end
    #1 i_sample_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL push_timeout: ready never seen, required ready within %0d clocks", 4 * TD);
    end
  endtask

  // Advance to the negedge inside the next tick cycle.
  task automatic wait_tick();
    bit seen;
    seen = 0;
    @(negedge i_clk);
    for (int n = 0; n < 4 * TD; n++) begin
      if (tb_tick) begin
        seen = 1;
        break;
      end
      @(negedge i_clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL tick_timeout: no tick within %0d clocks", 4 * TD);
    end
  endtask

  // From a tick cycle T, move to the negedge of T+2 where the DAC word lands.
  task automatic to_output();
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    int  pulses;
    bit  prev_tick;
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (o_dac_out !== 16'h8000 || o_sample_ready !== 1'b1 || o_dac_load !== 1'b0 ||
        o_clip !== 1'b0 || o_clip_count !== 16'h0000 || o_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: dac=%h rdy=%b load=%b clip=%b cnt=%h und=%b, required 8000 1 0 0 0000 0",
               o_dac_out, o_sample_ready, o_dac_load, o_clip, o_clip_count, o_underrun);
    end
    i_reset = 1'b1;
    prev_tick = tb_tick;
    pulses = 0;
    for (int n = 0; n < 3 * TD; n++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_underrun !== prev_tick) begin
        n_fail++;
        $display("FAIL idle_underrun cycle %0d: got %b, required %b", n, o_underrun, prev_tick);
      end
      if (o_underrun === 1'b1) pulses++;
      prev_tick = tb_tick;
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL idle_underrun_count: got %0d, required 3", pulses);
    end
    n_checks++;
    if (load_cnt != 0 || o_dac_out !== 16'h8000 || o_sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_output: loads=%0d dac=%h rdy=%b, required 0 8000 1",
               load_cnt, o_dac_out, o_sample_ready);
    end
  endtask

  task automatic test_basic();
    bit at;
    int loads_before;
    i_gain_shift = 3'd0;
    push(24'h000008, at);
    wait_tick();
    loads_before = load_cnt;
    @(negedge i_clk);
    n_checks++;
    if (o_dac_load !== 1'b0 || o_dac_out !== 16'h8000) begin
      n_fail++;
      $display("FAIL basic_latency: at T+1 load=%b dac=%h, required 0 8000", o_dac_load, o_dac_out);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_dac_out !== 16'h8001 || o_dac_load !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_out: dac=%h load=%b, required 8001 1", o_dac_out, o_dac_load);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_dac_load !== 1'b0 || load_cnt != loads_before + 1) begin
      n_fail++;
      $display("FAIL basic_single_load: load=%b pulses=%0d, required 0 1",
               o_dac_load, load_cnt - loads_before);
    end
  endtask

  task automatic test_gain();
    bit at;
    i_gain_shift = 3'd2;
    push(24'h000100, at);
    wait_tick();
    to_output();
    n_checks++;
    if (o_dac_out !== 16'h8008 || o_dac_load !== 1'b1) begin
      n_fail++;
      $display("FAIL gain2: dac=%h load=%b, required 8008 1", o_dac_out, o_dac_load);
    end
    i_gain_shift = 3'd7;
    push(24'h000100, at);
    wait_tick();
    to_output();
    n_checks++;
    if (o_dac_out !== 16'h8000 || o_dac_load !== 1'b1) begin
      n_fail++;
      $display("FAIL gain7: dac=%h load=%b, required 8000 1", o_dac_out, o_dac_load);
    end
    i_gain_shift = 3'd0;
  endtask

  task automatic test_back_to_back();
    bit at_a;
    bit at_b;
    push(24'h000080, at_a);
    push(24'hFFFF00, at_b);
    n_checks++;
    if (at_b !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept_at_tick: handshake on tick=%b, required 1", at_b);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (o_dac_out !== 16'h8010 || o_dac_load !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: dac=%h load=%b, required 8010 1", o_dac_out, o_dac_load);
    end
    n_checks++;
    if (o_sample_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready_while_pending: got %b, required 0", o_sample_ready);
    end
    wait_tick();
    to_output();
    n_checks++;
    if (o_dac_out !== 16'h7FE0 || o_dac_load !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: dac=%h load=%b, required 7fe0 1", o_dac_out, o_dac_load);
    end
  endtask

  task automatic test_clip();
    bit at;
    int high;
    push(24'h7FFFFF, at);
    wait_tick();
    to_output();
    n_checks++;
    if (o_dac_out !== 16'hFFFF || o_clip !== 1'b1 || o_clip_count !== 16'd1) begin
      n_fail++;
      $display("FAIL clip_pos: dac=%h clip=%b cnt=%0d, required ffff 1 1", o_dac_out, o_clip, o_clip_count);
    end
    high = 0;
    while (o_clip === 1'b1 && high < 5000) begin
      high++;
      @(negedge i_clk);
    end
    n_checks++;
    if (high != 4096) begin
      n_fail++;
      $display("FAIL clip_hold: high for %0d clocks, required 4096", high);
    end
    push(24'h800000, at);
    wait_tick();
    to_output();
    n_checks++;
    if (o_dac_out !== 16'h0000 || o_clip !== 1'b1 || o_clip_count !== 16'd2) begin
      n_fail++;
      $display("FAIL clip_neg: dac=%h clip=%b cnt=%0d, required 0000 1 2", o_dac_out, o_clip, o_clip_count);
    end
  endtask

  task automatic test_mute_clear();
    bit at;
    int n;
    n = 0;
    while (o_clip === 1'b1 && n < 5000) begin
      n++;
      @(negedge i_clk);
    end
    n_checks++;
    if (o_clip !== 1'b0) begin
      n_fail++;
      $display("FAIL clip_release: clip=%b after %0d clocks, required 0", o_clip, n);
    end
    i_mute = 1'b1;
    push(24'h7FFFFF, at);
    wait_tick();
    to_output();
    n_checks++;
    if (o_dac_out !== 16'h8000 || o_dac_load !== 1'b1 || o_clip !== 1'b0 || o_clip_count !== 16'd2) begin
      n_fail++;
      $display("FAIL mute: dac=%h load=%b clip=%b cnt=%0d, required 8000 1 0 2",
               o_dac_out, o_dac_load, o_clip, o_clip_count);
    end
    i_mute = 1'b0;
    push(24'h7FFFFF, at);
    wait_tick();
    @(posedge i_clk);
    @(negedge i_clk);
    i_clip_clear = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_clip_clear = 1'b0;
    n_checks++;
    if (o_clip_count !== 16'd1 || o_dac_out !== 16'hFFFF || o_clip !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_with_clip: cnt=%0d dac=%h clip=%b, required 1 ffff 1",
               o_clip_count, o_dac_out, o_clip);
    end
    i_clip_clear = 1'b1;
    @(negedge i_clk);
    i_clip_clear = 1'b0;
    n_checks++;
    if (o_clip_count !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_alone: cnt=%0d, required 0", o_clip_count);
    end
  endtask

  task automatic test_mid_reset();
    bit at;
    int loads_before;
    int pulses;
    push(24'h000008, at);
    i_reset = 1'b0;
    #1;
    n_checks++;
    if (o_sample_ready !== 1'b1 || o_dac_out !== 16'h8000 || o_clip !== 1'b0 ||
        o_clip_count !== 16'd0 || o_dac_load !== 1'b0 || o_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_values: rdy=%b dac=%h clip=%b cnt=%0d load=%b und=%b, required 1 8000 0 0 0 0",
               o_sample_ready, o_dac_out, o_clip, o_clip_count, o_dac_load, o_underrun);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    loads_before = load_cnt;
    pulses = 0;
    for (int k = 0; k < 2 * TD + 4; k++) begin
      @(negedge i_clk);
      if (o_underrun === 1'b1) pulses++;
    end
    n_checks++;
    if (load_cnt != loads_before || pulses != 2 || o_dac_out !== 16'h8000) begin
      n_fail++;
      $display("FAIL mid_reset_drop: loads=%0d underruns=%0d dac=%h, required 0 2 8000",
               load_cnt - loads_before, pulses, o_dac_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gain();
    test_back_to_back();
    test_clip();
    test_mute_clear();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
